// File: rtl/axi_stream_tp_chk.sv
// AXI4-Stream test-pattern checker: tracks pixel/line position per accepted beat and counts SOF/EOL/data/config errors.
// Optional TDATA == pixel-position check is enabled by defining TP_CHK_DATA_CHECK_EN.
module axi_stream_tp_chk #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              axi_stream_aclk,
    input  logic              axi_stream_aresetn,
    input  logic [DATA_W-1:0] axi_stream_tdata,
    input  logic              axi_stream_tvalid,
    input  logic              axi_stream_tuser,
    input  logic              axi_stream_tlast,
    output logic              axi_stream_tready,
    input  logic              chk_enable_i,
    input  logic [10:0]       chk_width_i,
    input  logic [10:0]       chk_height_i,
    input  logic              bp_enable_i,
    output logic              locked_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       err_cnt_o,
    output logic [3:0]        err_flags_o
);

    localparam int unsigned DIM_W  = 11;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_ACTIVE
    } state_e;

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic [DIM_W-1:0]   width_q, width_d;
    logic [DIM_W-1:0]   height_q, height_d;
    logic [DIM_W-1:0]   pix_q, pix_d;
    logic [DIM_W-1:0]   line_q, line_d;
    logic [CNT_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [3:0]         err_flags_q, err_flags_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic               tready_q, tready_d;
    logic               locked_q, locked_d;

    logic               beat;
    logic               en_rise;
    logic               take;
    logic               at_origin;
    logic [DIM_W-1:0]   eff_pix;
    logic [DIM_W-1:0]   eff_line;
    logic               last_pix;
    logic               last_line;
    logic               sof_err;
    logic               eol_err;
    logic               data_err;
    logic [1:0]         n_err;
    logic [CNT_W:0]     err_sum;

    // Beat qualification and per-beat checks; a SOF beat is always treated as pixel 0 / line 0.
    assign beat      = axi_stream_tvalid & tready_q;
    assign en_rise   = chk_enable_i & ~en_q;
    assign at_origin = (pix_q == '0) && (line_q == '0);
    assign eff_pix   = axi_stream_tuser ? '0 : pix_q;
    assign eff_line  = axi_stream_tuser ? '0 : line_q;
    assign last_pix  = (eff_pix == DIM_W'(width_q - 11'd1));
    assign last_line = (eff_line == DIM_W'(height_q - 11'd1));
    assign take      = beat && ((state_q == S_ACTIVE) ||
                                ((state_q == S_WAIT_SOF) && axi_stream_tuser));
    assign sof_err   = beat && (state_q == S_ACTIVE) && (axi_stream_tuser != at_origin);
    assign eol_err   = take && (axi_stream_tlast != last_pix);

`ifdef TP_CHK_DATA_CHECK_EN
    assign data_err  = take && (axi_stream_tdata != DATA_W'(eff_pix));
`else
    logic unused_tdata;
    assign unused_tdata = ^axi_stream_tdata;
    assign data_err     = 1'b0;
`endif

    assign n_err   = 2'(sof_err) + 2'(eol_err) + 2'(data_err);
    assign err_sum = {1'b0, err_cnt_q} + 17'(n_err);

    always_comb begin
        state_d     = state_q;
        en_d        = chk_enable_i;
        width_d     = width_q;
        height_d    = height_q;
        pix_d       = pix_q;
        line_d      = line_q;
        frame_d     = frame_q;
        err_cnt_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        err_flags_d = err_flags_q | {1'b0, data_err, eol_err, sof_err};
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};

        if (take) begin
            if (last_pix || axi_stream_tlast) begin
                pix_d  = '0;
                line_d = last_line ? '0 : DIM_W'(eff_line + 11'd1);
            end else begin
                pix_d  = DIM_W'(eff_pix + 11'd1);
                line_d = eff_line;
            end
            if (last_pix && last_line) begin
                frame_d = CNT_W'(frame_q + 16'd1);
            end
        end

        case (state_q)
            S_WAIT_SOF: if (take) state_d = S_ACTIVE;
            default:    state_d = state_q;
        endcase

        // Enable drop parks in IDLE with results held; a fresh rising edge restarts everything.
        if (!chk_enable_i) begin
            state_d = S_IDLE;
        end else if (en_rise) begin
            width_d     = chk_width_i;
            height_d    = chk_height_i;
            pix_d       = '0;
            line_d      = '0;
            frame_d     = '0;
            err_cnt_d   = '0;
            err_flags_d = '0;
            state_d     = S_WAIT_SOF;
            if ((chk_width_i == '0) || (chk_height_i == '0)) begin
                state_d     = S_IDLE;
                err_flags_d = 4'b1000;
                err_cnt_d   = 16'd1;
            end
        end

        tready_d = (state_d != S_IDLE) && (bp_enable_i ? lfsr_d[0] : 1'b1);
        locked_d = (state_d == S_ACTIVE);
    end

    // en_q resets high so an enable held across reset is not mistaken for a rising edge.
    always_ff @(posedge axi_stream_aclk or negedge axi_stream_aresetn) begin
        if (!axi_stream_aresetn) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b1;
            width_q     <= '0;
            height_q    <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            frame_q     <= '0;
            err_cnt_q   <= '0;
            err_flags_q <= '0;
            lfsr_q      <= LFSR_SEED;
            tready_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            width_q     <= width_d;
            height_q    <= height_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
            lfsr_q      <= lfsr_d;
            tready_q    <= tready_d;
            locked_q    <= locked_d;
        end
    end

    assign axi_stream_tready = tready_q;
    assign locked_o          = locked_q;
    assign frame_cnt_o       = frame_q;
    assign err_cnt_o         = err_cnt_q;
    assign err_flags_o       = err_flags_q;

endmodule

// File: doc/axi_stream_tp_chk.md
AXI_STREAM_TP_CHK -- requirements
Module: axi_stream_tp_chk

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the TDATA width in bits; only 8 is supported.
REQ-002 axi_stream_i.ACLK  input  1  SHALL be the single clock; every flop is clocked on its rising edge.
REQ-003 axi_stream_i.ARESETn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 axi_stream_i SHALL be the axi4_stream_if sink modport: TDATA, TVALID, TUSER[0] (SOF) and TLAST (EOL) are inputs; TREADY is the output; TKEEP is ignored.
REQ-005 chk_enable_i  input  1  SHALL be the checker enable, level-sensitive.
REQ-006 chk_width_i  input  11  SHALL give the expected pixels per line.
REQ-007 chk_height_i  input  11  SHALL give the expected lines per frame.
REQ-008 bp_enable_i  input  1  SHALL enable pseudo-random backpressure on TREADY.
REQ-009 locked_o  output  1  SHALL be high while in state ACTIVE.
REQ-010 frame_cnt_o  output  16  SHALL count complete frames received.
REQ-011 err_cnt_o  output  16  SHALL count errors of all kinds, saturating at 16'hFFFF.
REQ-012 err_flags_o  output  4  SHALL hold sticky error flags: [0] SOF, [1] EOL, [2] data, [3] config.

Function
REQ-013 The checker SHALL count a beat only when TVALID and TREADY are both high on a rising edge; counters and checks SHALL ignore all other cycles.
REQ-014 On a chk_enable_i rising edge (registered 0->1), the checker SHALL:
 - latch chk_width_i and chk_height_i into width_r and height_r;
 - clear all counters and err_flags_o;
 - enter WAIT_SOF, or IDLE with err_flags_o[3] set if either value is 0.
REQ-015 The checker SHALL implement states IDLE, WAIT_SOF and ACTIVE.
 - IDLE: TREADY=0.
 - WAIT_SOF: accepted beats without TUSER are discarded; a beat with TUSER=1 is pixel 0, line 0, and the checker enters ACTIVE.
 - ACTIVE: all checks run.
 - chk_enable_i low in any state -> IDLE on the next edge; counters and flags hold their values.
REQ-016 TREADY SHALL be registered and high in WAIT_SOF/ACTIVE when bp_enable_i=0; when bp_enable_i=1 it SHALL equal lfsr[0].
REQ-017 lfsr SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1, advancing every cycle.
REQ-018 In ACTIVE, the pixel position SHALL advance per accepted beat. At pixel width_r-1, the pixel count wraps to 0 and the line count increments. At the last pixel of line height_r-1, the line count wraps to 0 and frame_cnt_o increments, wrapping at 16 bits.
REQ-019 A SOF error SHALL be recorded when TUSER=1 on any beat other than pixel 0/line 0, or TUSER=0 on the pixel 0/line 0 beat. A mid-frame SOF SHALL resynchronise: that beat becomes pixel 0/line 0 and frame_cnt_o does not increment.
REQ-020 An EOL error SHALL be recorded when TLAST=1 before pixel width_r-1; the next beat is then pixel 0 of the next line. It SHALL also be recorded when TLAST=0 at pixel width_r-1; the position wraps anyway.
REQ-021 When one beat has both a SOF error and an EOL error, both flags SHALL be set and err_cnt_o SHALL increment by 2, still saturating.
REQ-022 Every error SHALL set its sticky flag and increment err_cnt_o, with a 1-cycle latency from the accepted beat.
REQ-023 locked_o, frame_cnt_o, err_cnt_o and err_flags_o SHALL all be registered outputs.

Reset
REQ-024 While ARESETn=0, the block SHALL hold:
 - state IDLE and TREADY=0;
 - locked_o=0, frame_cnt_o=0, err_cnt_o=0, err_flags_o=0;
 - width_r=0, height_r=0, all position counters 0;
 - lfsr=16'hACE1.
REQ-025 Reset assertion mid-frame SHALL take effect immediately (asynchronous). After deassertion the checker SHALL wait for a fresh chk_enable_i rising edge.

Configuration
REQ-026 Macro TP_CHK_DATA_CHECK_EN defined: in ACTIVE, each accepted beat SHALL be compared against TDATA == pixel position[7:0]; a mismatch sets err_flags_o[2] and counts as an error.
REQ-027 Macro TP_CHK_DATA_CHECK_EN undefined: TDATA SHALL be ignored and err_flags_o[2] SHALL be tied to 0.

Verification
REQ-028 Clean stream: width=4, height=3, bp off, 2 frames -> frame_cnt_o=2, err_cnt_o=0, locked_o=1 after the first SOF.
REQ-029 Backpressure: same stream with bp_enable_i=1 and a source honouring TREADY -> frame_cnt_o=2, err_cnt_o=0; TREADY toggles per the LFSR sequence from 16'hACE1.
REQ-030 Early TLAST: width=4, TLAST on pixel 2 of line 0 -> err_flags_o=4'b0010, err_cnt_o=1; the next beat is checked as pixel 0/line 1.
REQ-031 Mid-frame SOF: TUSER on line 1 pixel 1 -> err_flags_o[0]=1, err_cnt_o=1, frame_cnt_o unchanged; the following frame completes with no further errors.
REQ-032 Data check (macro defined): TDATA=8'h05 at pixel 2 -> err_flags_o[2]=1, err_cnt_o=1. With the macro undefined, the same stimulus gives err_cnt_o=0.
REQ-033 Config and reset:
 - chk_width_i=0 on enable -> err_flags_o=4'b1000, TREADY stays 0.
 - ARESETn pulsed mid-frame -> all outputs 0; locked_o stays 0 until the next enable edge and SOF.
